// File: rtl/fetch_bundle_stage_pkg.sv
// Shared types and constants for the bundle fetch stage.
package fetch_bundle_stage_pkg;

  // Default geometry of an instruction bundle and its index
  localparam int FB_PC_W     = 4;
  localparam int FB_SLOT0_W  = 32;
  localparam int FB_SLOT1_W  = 16;
  localparam int FB_BUNDLE_W = FB_SLOT0_W + FB_SLOT1_W;

  // Fetch control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Full-length slot lives in the upper bits of the bundle
  function automatic logic [FB_SLOT0_W-1:0] slot0_of(input logic [FB_BUNDLE_W-1:0] bundle);
    return bundle[FB_BUNDLE_W-1:FB_SLOT1_W];
  endfunction

  // Compressed slot lives in the lower bits of the bundle
  function automatic logic [FB_SLOT1_W-1:0] slot1_of(input logic [FB_BUNDLE_W-1:0] bundle);
    return bundle[FB_SLOT1_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_bundle_stage_if_id_reg.sv
// IF/ID pipeline register: holds {slot0, slot1, pc} with a valid/ready
// handshake toward decode. Flush beats load; load beats drain.
module fetch_bundle_stage_if_id_reg
  import fetch_bundle_stage_pkg::*;
#(
  parameter int PC_W    = FB_PC_W,
  parameter int SLOT0_W = FB_SLOT0_W,
  parameter int SLOT1_W = FB_SLOT1_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic [SLOT0_W-1:0] load_slot0,
  input  logic [SLOT1_W-1:0] load_slot1,
  input  logic [PC_W-1:0]    load_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [SLOT0_W-1:0] id_slot0,
  output logic [SLOT1_W-1:0] id_slot1,
  output logic [PC_W-1:0]    id_pc
);

  logic               valid_reg;
  logic [SLOT0_W-1:0] slot0_reg;
  logic [SLOT1_W-1:0] slot1_reg;
  logic [PC_W-1:0]    pc_reg;

  // Register update: reset clears, flush drops, load captures, accept drains
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      slot0_reg <= '0;
      slot1_reg <= '0;
      pc_reg    <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      slot0_reg <= load_slot0;
      slot1_reg <= load_slot1;
      pc_reg    <= load_pc;
    end else if (valid_reg && id_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign id_valid = valid_reg;
  assign id_slot0 = slot0_reg;
  assign id_slot1 = slot1_reg;
  assign id_pc    = pc_reg;

endmodule

// File: rtl/fetch_bundle_stage.sv
// Bundle fetch stage: owns the PC, drives the instruction-memory index,
// captures returned bundles into the IF/ID register, handles redirects
// and stops on an empty bundle.
module fetch_bundle_stage
  import fetch_bundle_stage_pkg::*;
#(
  parameter int PC_W         = FB_PC_W,
  parameter int SLOT0_W      = FB_SLOT0_W,
  parameter int SLOT1_W      = FB_SLOT1_W,
  parameter bit HALT_ON_ZERO = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [PC_W-1:0]            pc_4bits,
  input  logic [SLOT0_W+SLOT1_W-1:0] bundle_in,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [SLOT0_W-1:0]         id_slot0,
  output logic [SLOT1_W-1:0]         id_slot1,
  output logic [PC_W-1:0]            id_pc,
  output logic                       halted
);

  localparam int BUNDLE_W = SLOT0_W + SLOT1_W;

  fetch_state_e    state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic            load, flush, adv, bundle_empty;

  assign bundle_empty = (bundle_in == '0);
  assign adv          = (state_reg == ST_RUN) && (!id_valid || id_ready);

  // State and PC registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Next state, next PC and IF/ID controls; redirect overrides everything
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    load       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      state_next = ST_RUN;
      pc_next    = redirect_pc;
      flush      = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_RUN;
        ST_RUN: begin
          if (adv) begin
            if (HALT_ON_ZERO && bundle_empty) begin
              // Hold PC at the empty index; held bundle still drains
              state_next = ST_HALT;
            end else begin
              load    = 1'b1;
              pc_next = pc_reg + PC_W'(1);
            end
          end
        end
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  fetch_bundle_stage_if_id_reg #(
    .PC_W    (PC_W),
    .SLOT0_W (SLOT0_W),
    .SLOT1_W (SLOT1_W)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .flush      (flush),
    .load_slot0 (bundle_in[BUNDLE_W-1:SLOT1_W]),
    .load_slot1 (bundle_in[SLOT1_W-1:0]),
    .load_pc    (pc_reg),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_slot0   (id_slot0),
    .id_slot1   (id_slot1),
    .id_pc      (id_pc)
  );

  assign pc_4bits = pc_reg;
  assign halted   = (state_reg == ST_HALT);

endmodule

// File: tb/tb_fetch_bundle_stage.sv
// Directed bench for fetch_bundle_stage: one instance halts on empty
// bundles, a second passes them through to exercise PC wrap.
module tb_fetch_bundle_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Instance A: HALT_ON_ZERO=1 with a small program image
  logic        reset_a, redir_a, ready_a;
  logic [3:0]  redir_pc_a, pc_a, id_pc_a;
  logic [47:0] bundle_a;
  logic        id_valid_a, halted_a;
  logic [31:0] id_slot0_a;
  logic [15:0] id_slot1_a;
  logic [47:0] mem [16];

  always_comb bundle_a = mem[pc_a];

  fetch_bundle_stage #(.HALT_ON_ZERO(1'b1)) dut_a (
    .clk(clk), .reset(reset_a), .pc_4bits(pc_a), .bundle_in(bundle_a),
    .redirect_valid(redir_a), .redirect_pc(redir_pc_a), .id_ready(ready_a),
    .id_valid(id_valid_a), .id_slot0(id_slot0_a), .id_slot1(id_slot1_a),
    .id_pc(id_pc_a), .halted(halted_a)
  );

  // Instance B: HALT_ON_ZERO=0, memory returns all-zero bundles
  logic        reset_b, redir_b, ready_b;
  logic [3:0]  redir_pc_b, pc_b, id_pc_b;
  logic [47:0] bundle_b;
  logic        id_valid_b, halted_b;
  logic [31:0] id_slot0_b;
  logic [15:0] id_slot1_b;

  fetch_bundle_stage #(.HALT_ON_ZERO(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .pc_4bits(pc_b), .bundle_in(bundle_b),
    .redirect_valid(redir_b), .redirect_pc(redir_pc_b), .id_ready(ready_b),
    .id_valid(id_valid_b), .id_slot0(id_slot0_b), .id_slot1(id_slot1_b),
    .id_pc(id_pc_b), .halted(halted_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expected contents of A held bundle, built independently from mem index
  function automatic logic [31:0] exp_s0(input int i);
    return 32'hC0DE_0000 + 32'(i * 17);
  endfunction
  function automatic logic [15:0] exp_s1(input int i);
    return 16'hB000 + 16'(i);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {exp_s0(i), exp_s1(i)};
    mem[12] = 48'h0;
    bundle_b = 48'h0;
    reset_a = 1'b0; redir_a = 1'b0; redir_pc_a = 4'd0; ready_a = 1'b1;
    reset_b = 1'b0; redir_b = 1'b0; redir_pc_b = 4'd0; ready_b = 1'b1;

    // Reset for two edges
    step(); step();
    check("rst_valid", 64'(id_valid_a), 64'd0);
    check("rst_pc", 64'(pc_a), 64'd0);
    check("rst_halted", 64'(halted_a), 64'd0);
    check("rst_id_pc", 64'(id_pc_a), 64'd0);
    check("rst_slot0", 64'(id_slot0_a), 64'd0);

    // Release: IDLE for one cycle, then first capture
    reset_a = 1'b1;
    step();
    check("idle_valid", 64'(id_valid_a), 64'd0);
    check("idle_pc", 64'(pc_a), 64'd0);
    step();
    check("first_valid", 64'(id_valid_a), 64'd1);
    check("first_id_pc", 64'(id_pc_a), 64'd0);
    check("first_slot0", 64'(id_slot0_a), 64'(exp_s0(0)));
    check("first_slot1", 64'(id_slot1_a), 64'(exp_s1(0)));
    check("first_pc", 64'(pc_a), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("run_valid", 64'(id_valid_a), 64'd1);
      check("run_id_pc", 64'(id_pc_a), 64'(k));
    end

    // Backpressure with id_pc=3 held
    ready_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_valid", 64'(id_valid_a), 64'd1);
      check("bp_id_pc", 64'(id_pc_a), 64'd3);
      check("bp_slot0", 64'(id_slot0_a), 64'(exp_s0(3)));
      check("bp_slot1", 64'(id_slot1_a), 64'(exp_s1(3)));
      check("bp_pc", 64'(pc_a), 64'd4);
    end
    ready_a = 1'b1;
    for (int k = 4; k <= 11; k++) begin
      step();
      check("run2_valid", 64'(id_valid_a), 64'd1);
      check("run2_id_pc", 64'(id_pc_a), 64'(k));
      check("run2_slot1", 64'(id_slot1_a), 64'(exp_s1(k)));
    end

    // Empty bundle at 12: halt, PC frozen, held bundle drained
    for (int k = 0; k < 3; k++) begin
      step();
      check("halt_halted", 64'(halted_a), 64'd1);
      check("halt_pc", 64'(pc_a), 64'd12);
      check("halt_valid", 64'(id_valid_a), 64'd0);
    end

    // Redirect out of HALT to 2
    redir_a = 1'b1; redir_pc_a = 4'd2;
    step();
    redir_a = 1'b0;
    check("redir_halted", 64'(halted_a), 64'd0);
    check("redir_pc", 64'(pc_a), 64'd2);
    check("redir_valid", 64'(id_valid_a), 64'd0);
    step();
    check("tgt_valid", 64'(id_valid_a), 64'd1);
    check("tgt_id_pc", 64'(id_pc_a), 64'd2);
    check("tgt_slot1", 64'(id_slot1_a), 64'(exp_s1(2)));

    // Redirect to 7 on the same edge as an accept
    redir_a = 1'b1; redir_pc_a = 4'd7;
    step();
    redir_a = 1'b0;
    check("racc_valid", 64'(id_valid_a), 64'd0);
    check("racc_pc", 64'(pc_a), 64'd7);
    step();
    check("racc_cap_valid", 64'(id_valid_a), 64'd1);
    check("racc_cap_id_pc", 64'(id_pc_a), 64'd7);
    check("racc_cap_slot0", 64'(id_slot0_a), 64'(exp_s0(7)));

    // Instance B: release together with a redirect to 14, then wrap
    reset_b = 1'b1; redir_b = 1'b1; redir_pc_b = 4'd14;
    step();
    redir_b = 1'b0;
    check("b_redir_pc", 64'(pc_b), 64'd14);
    check("b_redir_valid", 64'(id_valid_b), 64'd0);
    step();
    check("b_zero_valid", 64'(id_valid_b), 64'd1);
    check("b_zero_id_pc", 64'(id_pc_b), 64'd14);
    check("b_zero_slot0", 64'(id_slot0_b), 64'd0);
    check("b_zero_halted", 64'(halted_b), 64'd0);
    step();
    check("b_wrap15_id_pc", 64'(id_pc_b), 64'd15);
    check("b_wrap15_pc", 64'(pc_b), 64'd0);
    step();
    check("b_wrap0_id_pc", 64'(id_pc_b), 64'd0);
    check("b_wrap0_valid", 64'(id_valid_b), 64'd1);
    check("b_wrap0_pc", 64'(pc_b), 64'd1);

    // Mid-run reset discards the held bundle
    reset_b = 1'b0;
    step();
    check("b_mrst_valid", 64'(id_valid_b), 64'd0);
    check("b_mrst_pc", 64'(pc_b), 64'd0);
    check("b_mrst_id_pc", 64'(id_pc_b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_bundle_stage.md
Name: fetch_bundle_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory; also consumes its output.
- Owns the bundle program counter and drives the 4-bit bundle index into the instruction memory.
- Captures the returned 48-bit bundle (32-bit slot0 + 16-bit compressed slot1) into an IF/ID pipeline register, with a valid/ready handshake toward decode.
- Handles branch redirect/flush, and halts on an all-zero (empty) bundle.

Parameters:
- PC_W, 4, width of the bundle index; matches the instruction-memory select width.
- SLOT0_W, 32, width of the full-length instruction slot (bundle bits [47:16]).
- SLOT1_W, 16, width of the compressed instruction slot (bundle bits [15:0]).
- HALT_ON_ZERO, 1, when 1 an all-zero bundle stops fetch; when 0 it is passed through like any other bundle.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- pc_4bits  out  PC_W  bundle index to instruction memory; equals the current PC register.
- bundle_in  in  SLOT0_W+SLOT1_W  bundle returned combinationally by instruction memory for pc_4bits.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  PC_W  redirect target bundle index.
- id_ready  in  1  decode can accept this cycle.
- id_valid  out  1  IF/ID register holds a valid bundle.
- id_slot0  out  SLOT0_W  held bundle[47:16].
- id_slot1  out  SLOT1_W  held bundle[15:0].
- id_pc  out  PC_W  index the held bundle was fetched from.
- halted  out  1  fetch stopped on an empty bundle.

Behaviour:
- Reset (reset==0 at an edge):
  - PC=0; id_valid=0; id_slot0=0; id_slot1=0; id_pc=0; halted=0; FSM=IDLE.
  - Reset mid-operation discards the held bundle immediately.
- FSM states: IDLE, RUN, HALT.
  - IDLE: one cycle, no capture, PC held. Goes to RUN next cycle, or acts on a redirect if one is present.
  - RUN: normal fetch.
  - HALT: no capture, PC frozen, halted=1. Left only by redirect (to RUN) or reset.
- Advance condition: adv = (FSM==RUN) && (!id_valid || id_ready).
- On adv with a non-empty bundle:
  - IF/ID captures bundle_in, with id_pc = PC.
  - id_valid is set to 1.
  - PC becomes PC+1, modulo 2^PC_W (15 wraps to 0, no flag).
- On adv with bundle_in==0 and HALT_ON_ZERO=1:
  - Nothing is captured; PC is held at the empty index.
  - FSM goes to HALT; halted=1 from the next cycle.
  - An already-held bundle is not dropped; it drains through the handshake.
- Handshake:
  - id_valid && id_ready completes a transfer.
  - With no new capture on that edge, id_valid clears to 0.
  - With id_valid=1 and id_ready=0, all id_* outputs hold stable and PC holds.
- Latency: a bundle fetched at index N appears on the id_* outputs 1 cycle after pc_4bits==N, provided adv.
- Redirect (highest priority, any state after reset):
  - PC becomes redirect_pc; id_valid becomes 0 (flush, even if id_ready=1 that cycle).
  - halted becomes 0; FSM becomes RUN.
  - No capture on the redirect edge.
  - The first bundle from the target appears one cycle after the redirect edge, via adv.
- Priority: reset > redirect > halt detect > normal advance.
- Redirect to the same index as the current PC is legal and simply flushes.
- pc_4bits is the PC register directly; it has no combinational path from any input.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/RUN/HALT).
  - Bundle-width constants: SLOT0_W, SLOT1_W, BUNDLE_W=48.
  - PC_W.
  - Slot field-select helpers.
- One natural sub-module: if_id_reg. It is the valid/ready pipeline register holding {slot0, slot1, pc} with load/flush controls. The PC and FSM stay in the top level.

Test Plan:
- Reset then straight run:
  - reset=0 for 2 cycles, then 1, id_ready=1, memory has non-zero bundles at 0..11.
  - Required: id_valid first rises 2 cycles after reset release with id_pc=0.
  - Then id_pc runs 1,2,...,11 on consecutive cycles.
- Backpressure:
  - id_ready=0 for 3 cycles while id_valid=1 with id_pc=3.
  - Required: id_slot0, id_slot1 and id_pc stay stable and pc_4bits stays 4.
  - On release, id_pc=4 follows the next cycle.
- Halt on empty:
  - Bundle at index 12 is 48'h0.
  - Required: after id_pc=11 is accepted, halted=1, pc_4bits stays 12 and id_valid=0 indefinitely.
- Redirect out of HALT:
  - redirect_valid=1, redirect_pc=2 while halted.
  - Required: next cycle halted=0 and pc_4bits=2.
  - The following cycle id_valid=1, id_pc=2, id_slot1 = bundle[15:0] of index 2.
- Redirect with simultaneous accept:
  - id_valid=1, id_ready=1, redirect to 7 on the same edge.
  - Required: id_valid=0 next cycle (no stale bundle); next capture has id_pc=7.
- Wrap and mid-run reset:
  - HALT_ON_ZERO=0, all-zero bundles.
  - Required: id_pc goes 15 then 0.
  - Assert reset while id_valid=1: next cycle id_valid=0 and pc_4bits=0.
